// File: rtl/ball_motion_if.sv
// Drawer-facing bus of the pong ball motion stage: ball centre, its
// new-value strobe, and the drawer's busy back-pressure.
interface ball_motion_if;
    logic [7:0] x;
    logic [6:0] y;
    logic       pos_valid;
    logic       draw_busy;

    modport master (output x, output y, output pos_valid, input draw_busy);
    modport slave  (input x, input y, input pos_valid, output draw_busy);
endinterface

// File: rtl/ball_motion.sv
// Pong ball motion: advances the ball once per frame tick, bounces it off walls
// and paddles, scores missed balls. Optional macro BALL_SPEEDUP_EN: step grows per paddle hit.
module ball_motion #(
    parameter int RADIUS    = 4,
    parameter int SCREEN_W  = 160,
    parameter int SCREEN_H  = 120,
    parameter int TICK_DIV  = 833333,
    parameter int SPEED     = 1,
    parameter int PADDLE_H  = 16,
    parameter int PADDLE_XL = 4,
    parameter int PADDLE_XR = 155,
    parameter int WIN_SCORE = 7
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [6:0]    paddle_l_y,
    input  logic [6:0]    paddle_r_y,
    ball_motion_if.master bus,
    output logic [3:0]    score_l,
    output logic [3:0]    score_r,
    output logic          point,
    output logic          game_over
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_TICK = 3'd1;
    localparam logic [2:0] S_UPDATE    = 3'd2;
    localparam logic [2:0] S_PRESENT   = 3'd3;
    localparam logic [2:0] S_SERVE     = 3'd4;
    localparam logic [2:0] S_OVER      = 3'd5;

    localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [7:0]        X_CENTRE    = 8'(SCREEN_W / 2);
    localparam logic [6:0]        Y_CENTRE    = 7'(SCREEN_H / 2);
    localparam logic signed [8:0] R_S         = 9'(RADIUS);
    localparam logic signed [8:0] ZERO_S      = 9'sd0;
    localparam logic signed [8:0] YBOT_S      = 9'(SCREEN_H - 1);
    localparam logic signed [8:0] XEDGE_S     = 9'(SCREEN_W - 1);
    localparam logic signed [8:0] XL_S        = 9'(PADDLE_XL);
    localparam logic signed [8:0] XR_S        = 9'(PADDLE_XR);
    localparam logic signed [8:0] PH_S        = 9'(PADDLE_H - 1);
    localparam logic signed [8:0] Y_BOT_CLAMP = 9'(SCREEN_H - 1 - RADIUS);
    localparam logic [7:0]        X_BOUNCE_L  = 8'(PADDLE_XL + 1 + RADIUS);
    localparam logic [7:0]        X_BOUNCE_R  = 8'(PADDLE_XR - 1 - RADIUS);
    localparam logic [3:0]        WIN_S       = 4'(WIN_SCORE);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick;
    logic [7:0]        x_q, x_d;
    logic [6:0]        y_q, y_d;
    logic              dx_q, dx_d;
    logic              dy_q, dy_d;
    logic [3:0]        score_l_q, score_l_d;
    logic [3:0]        score_r_q, score_r_d;
    logic              left_scores_q, left_scores_d;
    logic              won;

    logic signed [8:0] step_s;
    logic signed [8:0] xs, ys, xc, yc, yw, pl_top, pr_top;
    logic [7:0]        xw;
    logic              dx_n, dy_n, lost_l, lost_r;

    function automatic logic [3:0] sat_inc_score(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

`ifdef BALL_SPEEDUP_EN
    logic [1:0] step_q, step_d;

    function automatic logic [1:0] sat_inc_step(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    assign step_s = signed'({7'd0, step_q});
`else
    assign step_s = 9'(SPEED);
`endif

    assign tick  = (cnt_q == CNT_LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // Candidate next position with wall clamps first, then paddle checks on the clamped y.
    always_comb begin
        xs     = signed'({1'b0, x_q});
        ys     = signed'({2'b00, y_q});
        pl_top = signed'({2'b00, paddle_l_y});
        pr_top = signed'({2'b00, paddle_r_y});
        xc     = dx_q ? xs + step_s : xs - step_s;
        yc     = dy_q ? ys + step_s : ys - step_s;
        dx_n   = dx_q;
        dy_n   = dy_q;
        yw     = yc;
        xw     = xc[7:0];
        lost_l = 1'b0;
        lost_r = 1'b0;

        if (yc - R_S <= ZERO_S) begin
            dy_n = 1'b1;
            yw   = R_S;
        end else if (yc + R_S >= YBOT_S) begin
            dy_n = 1'b0;
            yw   = Y_BOT_CLAMP;
        end

        if (!dx_q && (xc - R_S <= XL_S)) begin
            if (yw >= pl_top && yw <= pl_top + PH_S) begin
                dx_n = 1'b1;
                xw   = X_BOUNCE_L;
            end else if (xc - R_S <= ZERO_S) begin
                lost_l = 1'b1;
            end
        end

        if (dx_q && (xc + R_S >= XR_S)) begin
            if (yw >= pr_top && yw <= pr_top + PH_S) begin
                dx_n = 1'b0;
                xw   = X_BOUNCE_R;
            end else if (xc + R_S >= XEDGE_S) begin
                lost_r = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        score_l_d     = score_l_q;
        score_r_d     = score_r_q;
        left_scores_d = left_scores_q;
        won           = 1'b0;
`ifdef BALL_SPEEDUP_EN
        step_d        = step_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_PRESENT;
            end
            S_WAIT_TICK: begin
                if (tick && !bus.draw_busy) state_d = S_UPDATE;
            end
            S_UPDATE: begin
                if (lost_l || lost_r) begin
                    left_scores_d = lost_r;
                    state_d       = S_SERVE;
                end else begin
                    x_d     = xw;
                    y_d     = yw[6:0];
                    dx_d    = dx_n;
                    dy_d    = dy_n;
                    state_d = S_PRESENT;
`ifdef BALL_SPEEDUP_EN
                    // dx only flips on a paddle reflection
                    if (dx_n != dx_q) step_d = sat_inc_step(step_q);
`endif
                end
            end
            S_PRESENT: begin
                state_d = S_WAIT_TICK;
            end
            S_SERVE: begin
                // Serve toward the player who conceded.
                if (left_scores_q) begin
                    score_l_d = sat_inc_score(score_l_q);
                    won       = (score_l_d == WIN_S);
                    dx_d      = 1'b1;
                end else begin
                    score_r_d = sat_inc_score(score_r_q);
                    won       = (score_r_d == WIN_S);
                    dx_d      = 1'b0;
                end
                x_d     = X_CENTRE;
                y_d     = Y_CENTRE;
                state_d = won ? S_OVER : S_PRESENT;
`ifdef BALL_SPEEDUP_EN
                step_d  = 2'(SPEED);
`endif
            end
            S_OVER: begin
                if (start) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    x_d       = X_CENTRE;
                    y_d       = Y_CENTRE;
                    state_d   = S_PRESENT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            x_q           <= X_CENTRE;
            y_q           <= Y_CENTRE;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            left_scores_q <= 1'b0;
`ifdef BALL_SPEEDUP_EN
            step_q        <= 2'(SPEED);
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            y_q           <= y_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            score_l_q     <= score_l_d;
            score_r_q     <= score_r_d;
            left_scores_q <= left_scores_d;
`ifdef BALL_SPEEDUP_EN
            step_q        <= step_d;
`endif
        end
    end

    assign bus.x         = x_q;
    assign bus.y         = y_q;
    assign bus.pos_valid = (state_q == S_PRESENT);
    assign point         = (state_q == S_SERVE);
    assign game_over     = (state_q == S_OVER);
    assign score_l       = score_l_q;
    assign score_r       = score_r_q;

endmodule
